// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (request-to-send, odd parity, ack check)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN = 4
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_din_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dout_oe
);
  localparam int CMAX = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, WAITIDLE} state_t;
  state_t state, state_n;
  logic [1:0] clk_s, dat_s;
  logic filt;
  logic [FW-1:0] fcnt;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] nbit, nbit_n;
  logic [9:0] sh, sh_n;
  logic dbit, dbit_n, done_n, error_n;
  logic flip, fall, expired, inh_last;
  assign flip = (clk_s[1] != filt) && (fcnt == FW'(FILTER_LEN - 1));
  assign fall = flip && filt;
  assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign inh_last = cnt == CW'(INHIBIT_CYCLES - 1);
  assign busy = state != IDLE;
  assign rx_inhibit = busy;
  assign ps2_clk_oe = state == INHIBIT;
  assign ps2_dout_oe = (state == INHIBIT && inh_last) || (state == SEND && !dbit);
  always_ff @(posedge clk25 or posedge rst)
    if (rst) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      filt <= 1'b1;
      fcnt <= '0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk_in};
      dat_s <= {dat_s[0], ps2_din_in};
      if (clk_s[1] == filt || flip) fcnt <= '0;
      else fcnt <= fcnt + 1'b1;
      if (flip) filt <= clk_s[1];
    end
  always_ff @(posedge clk25 or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      nbit <= '0;
      sh <= '1;
      dbit <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      nbit <= nbit_n;
      sh <= sh_n;
      dbit <= dbit_n;
      done <= done_n;
      error <= error_n;
    end
  // One counter serves as inhibit timer and, from clock release on, as timeout timer.
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    nbit_n = nbit;
    sh_n = sh;
    dbit_n = dbit;
    done_n = 1'b0;
    error_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (wr) begin
          sh_n = {1'b1, ~^din, din};
          state_n = INHIBIT;
        end
      end
      INHIBIT:
        if (inh_last) begin
          state_n = SEND;
          cnt_n = '0;
          nbit_n = '0;
          dbit_n = 1'b0;
        end
      SEND, ACK, WAITIDLE:
        if (expired) begin
          error_n = 1'b1;
          state_n = IDLE;
        end else if (state == SEND) begin
          if (fall) begin
            dbit_n = sh[0];
            sh_n = {1'b1, sh[9:1]};
            nbit_n = nbit + 4'd1;
            if (nbit == 4'd9) state_n = ACK;
          end
        end else if (state == ACK) begin
          if (fall) begin
            error_n = dat_s[1];
            state_n = dat_s[1] ? IDLE : WAITIDLE;
          end
        end else if (clk_s[1] && dat_s[1]) begin
          done_n = 1'b1;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized checks of ps2_host_tx against a PS/2 device model
module tb_ps2_host_tx;
  localparam int INH = 50, TMO = 3000, H = 40;
  logic clk25 = 0, rst = 1, wr = 0;
  logic [7:0] din = 0;
  logic busy, done, error, rx_inhibit, ps2_clk_oe, ps2_dout_oe;
  logic ps2_clk_in, ps2_din_in;
  logic dev_clk = 1, dev_dat = 1, glitch = 0;
  int errors = 0, checks = 0, ndone = 0, nerr = 0, both = 0, inh_bad = 0;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe & ~glitch;
  assign ps2_din_in = dev_dat & ~ps2_dout_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(4)) dut (
    .clk25(clk25), .rst(rst), .wr(wr), .din(din), .busy(busy), .done(done), .error(error),
    .rx_inhibit(rx_inhibit), .ps2_clk_in(ps2_clk_in), .ps2_din_in(ps2_din_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dout_oe(ps2_dout_oe));

  always #20 clk25 = ~clk25;

  always @(negedge clk25) begin
    if (done) ndone++;
    if (error) nerr++;
    if (done && error) both++;
    if (rx_inhibit !== busy) inh_bad++;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  task automatic write(input logic [7:0] d);
    @(negedge clk25);
    din = d;
    wr = 1;
    @(negedge clk25);
    wr = 0;
  endtask

  task automatic wait_release(output int low);
    int t = 0;
    low = 0;
    while (!ps2_clk_oe && t < 200) begin @(negedge clk25); t++; end
    while (ps2_clk_oe && low < 5000) begin @(negedge clk25); low++; end
  endtask

  task automatic device_frame(input bit ack, input int glitch_at, output logic [10:0] got,
                              output int low, output int drop);
    got = '0;
    drop = 0;
    wait_release(low);
    got[0] = ps2_din_in;
    repeat (20) @(negedge clk25);
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 0;
      repeat (H) @(negedge clk25);
      dev_clk = 1;
      got[i] = ps2_din_in;
      if (!busy) drop++;
      if (i == glitch_at) begin
        repeat (H / 2) @(negedge clk25);
        glitch = 1;
        repeat (2) @(negedge clk25);
        glitch = 0;
        repeat (H / 2 - 2) @(negedge clk25);
      end else repeat (H) @(negedge clk25);
    end
    if (ack) dev_dat = 0;
    repeat (H / 2) @(negedge clk25);
    dev_clk = 0;
    repeat (H) @(negedge clk25);
    dev_clk = 1;
    repeat (H / 2) @(negedge clk25);
    dev_dat = 1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit ack, input int glitch_at,
                            input bit stray, input string name);
    logic [10:0] got, exp;
    int low, drop, d0, e0, t;
    exp = frame_of(d);
    d0 = ndone;
    e0 = nerr;
    write(d);
    if (stray) fork
      begin
        repeat (INH + 300) @(negedge clk25);
        din = 8'h55;
        wr = 1;
        @(negedge clk25);
        wr = 0;
      end
    join_none
    device_frame(ack, glitch_at, got, low, drop);
    t = 0;
    while (ndone == d0 && nerr == e0 && t < 500) begin @(negedge clk25); t++; end
    repeat (5) @(negedge clk25);
    checks++;
    if (low !== INH) begin errors++; $display("FAIL %s inhibit_len: got %0d want %0d", name, low, INH); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL %s frame: got %b want %b", name, got, exp); end
    checks++;
    if (ndone - d0 !== (ack ? 1 : 0)) begin errors++; $display("FAIL %s done_count: got %0d want %0d", name, ndone - d0, ack ? 1 : 0); end
    checks++;
    if (nerr - e0 !== (ack ? 0 : 1)) begin errors++; $display("FAIL %s error_count: got %0d want %0d", name, nerr - e0, ack ? 0 : 1); end
    checks++;
    if (drop !== 0) begin errors++; $display("FAIL %s busy_held: got %0d drops want 0", name, drop); end
    checks++;
    if ({busy, ps2_clk_oe, ps2_dout_oe} !== 3'b000) begin errors++; $display("FAIL %s idle_lines: got %b want 000", name, {busy, ps2_clk_oe, ps2_dout_oe}); end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk25);
    checks++;
    if ({busy, done, error, rx_inhibit, ps2_clk_oe, ps2_dout_oe} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000", {busy, done, error, rx_inhibit, ps2_clk_oe, ps2_dout_oe});
    end
    rst = 0;
    repeat (3) @(negedge clk25);
  endtask

  task automatic test_known_bytes;
    send_frame(8'hED, 1, 0, 0, "set_leds");
    send_frame(8'h07, 1, 0, 0, "parity0");
    send_frame(8'h00, 1, 0, 0, "parity1");
  endtask

  task automatic test_random;
    for (int n = 0; n < 4; n++) send_frame(8'($urandom), 1, 0, 0, "random");
  endtask

  task automatic test_no_ack;
    send_frame(8'hFF, 0, 0, 0, "no_ack");
  endtask

  task automatic test_wr_while_busy;
    send_frame(8'hED, 1, 0, 1, "wr_busy");
  endtask

  task automatic test_glitch;
    send_frame(8'($urandom), 1, 4, 0, "glitch");
  endtask

  task automatic test_timeout;
    int low, c, d0, e0;
    d0 = ndone;
    e0 = nerr;
    write(8'hA5);
    wait_release(low);
    c = 0;
    while (!error && c < TMO + 100) begin @(negedge clk25); c++; end
    checks++;
    if (c !== TMO) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", c, TMO); end
    checks++;
    if ({ps2_clk_oe, ps2_dout_oe, busy} !== 3'b000) begin errors++; $display("FAIL timeout_lines: got %b want 000", {ps2_clk_oe, ps2_dout_oe, busy}); end
    repeat (5) @(negedge clk25);
    checks++;
    if (nerr - e0 !== 1 || ndone !== d0) begin errors++; $display("FAIL timeout_pulses: got err=%0d done=%0d want 1 0", nerr - e0, ndone - d0); end
  endtask

  task automatic test_reset_mid;
    int low, d0, e0;
    d0 = ndone;
    e0 = nerr;
    write(8'hF0);
    wait_release(low);
    repeat (20) @(negedge clk25);
    for (int i = 0; i < 3; i++) begin
      dev_clk = 0;
      repeat (H) @(negedge clk25);
      dev_clk = 1;
      repeat (H) @(negedge clk25);
    end
    checks++;
    if (ps2_dout_oe !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL pre_reset_drive: got oe=%b busy=%b want 1 1", ps2_dout_oe, busy); end
    rst = 1;
    #1;
    checks++;
    if ({busy, rx_inhibit, ps2_clk_oe, ps2_dout_oe} !== 4'b0) begin
      errors++;
      $display("FAIL async_reset: got %b want 0000", {busy, rx_inhibit, ps2_clk_oe, ps2_dout_oe});
    end
    @(negedge clk25);
    rst = 0;
    repeat (50) @(negedge clk25);
    checks++;
    if (ndone !== d0 || nerr !== e0) begin errors++; $display("FAIL reset_no_pulse: got done=%0d err=%0d want 0 0", ndone - d0, nerr - e0); end
  endtask

  task automatic test_invariants;
    checks++;
    if (both !== 0) begin errors++; $display("FAIL done_error_overlap: got %0d want 0", both); end
    checks++;
    if (inh_bad !== 0) begin errors++; $display("FAIL rx_inhibit_eq_busy: got %0d mismatched cycles want 0", inh_bad); end
  endtask

  initial begin
    test_reset;
    test_known_bytes;
    test_random;
    test_no_ack;
    test_wr_while_busy;
    test_glitch;
    test_timeout;
    test_reset_mid;
    test_invariants;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
